// File: rtl/nv_nvdla_pdp_med2d_row_pair_if.sv
// Beat stream into the row pairer and the A/B pair stream out of it.
interface nv_nvdla_pdp_med2d_row_pair_if #(
  parameter int unsigned DW = 112
);
  logic [DW-1:0] in_pd;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_a_pd;
  logic [DW-1:0] out_b_pd;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  // Producer of input beats and consumer of output pairs.
  modport master (
    output in_pd, in_valid, out_ready,
    input  in_ready, out_a_pd, out_b_pd, out_valid, out_last
  );

  // The row pairer itself.
  modport slave (
    input  in_pd, in_valid, out_ready,
    output in_ready, out_a_pd, out_b_pd, out_valid, out_last
  );
endinterface

// File: rtl/nv_nvdla_pdp_med2d_row_pair.sv
// Row pairer feeding the PDP 2x2 median core: buffers an even row, then
// pairs each odd-row beat with the buffered beat of the same column.
module nv_nvdla_pdp_med2d_row_pair #(
  parameter int unsigned MAX_W = 64,
  parameter int unsigned DW    = 112,
  parameter int unsigned CW    = 13
) (
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rstn,
  input  logic                              op_en,
  input  logic [CW-1:0]                     cfg_width_m1,
  input  logic [CW-1:0]                     cfg_height_m1,
  nv_nvdla_pdp_med2d_row_pair_if.slave      pd_if,
  output logic                              busy,
  output logic                              layer_done
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_PAIR   = 3'd2,
    S_SINGLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, row_q;
  logic [CW-1:0] width_m1_q, height_m1_q;
  logic [CW-1:0] width_sat;
  logic [DW-1:0] out_a_q, out_b_q;
  logic          out_valid_q, out_last_q;
  logic          busy_q, layer_done_q;
  logic [DW-1:0] line_buf [MAX_W];

  logic          in_ready_c;
  logic          accept;
  logic          col_end;
  logic          row_last;
  logic          load_out;
  logic          out_hs;

  // Oversized rows are clamped to the line-buffer depth.
  assign width_sat = (cfg_width_m1 >= CW'(MAX_W)) ? CW'(MAX_W - 1) : cfg_width_m1;

  // State register.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; row ends in PAIR pick DONE, SINGLE or another FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (op_en) begin
          state_d = (cfg_height_m1 != '0) ? S_FILL : S_SINGLE;
        end
      end
      S_FILL: begin
        if (accept && col_end) begin
          state_d = S_PAIR;
        end
      end
      S_PAIR: begin
        if (accept && col_end) begin
          if (row_last) begin
            state_d = S_DONE;
          end else if ((row_q + CW'(1)) == height_m1_q) begin
            state_d = S_SINGLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_SINGLE: begin
        if (accept && col_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_hs && out_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and datapath control decoded from the current state.
  always_comb begin
    in_ready_c = 1'b0;
    load_out   = 1'b0;
    case (state_q)
      S_FILL:           in_ready_c = 1'b1;
      S_PAIR, S_SINGLE: in_ready_c = !out_valid_q || pd_if.out_ready;
      default:          in_ready_c = 1'b0;
    endcase
    accept   = pd_if.in_valid && in_ready_c;
    col_end  = (col_q == width_m1_q);
    row_last = (row_q == height_m1_q);
    out_hs   = out_valid_q && pd_if.out_ready;
    if ((state_q == S_PAIR) || (state_q == S_SINGLE)) begin
      load_out = accept;
    end
  end

  // Layer bookkeeping: config capture, counters, busy and done pulse.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      width_m1_q   <= '0;
      height_m1_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      if ((state_q == S_IDLE) && op_en) begin
        width_m1_q  <= width_sat;
        height_m1_q <= cfg_height_m1;
        col_q       <= '0;
        row_q       <= '0;
        busy_q      <= 1'b1;
      end
      if (accept) begin
        col_q <= col_end ? '0 : col_q + CW'(1);
        if (col_end) begin
          row_q <= row_last ? '0 : row_q + CW'(1);
        end
      end
      if ((state_q == S_DONE) && out_hs && out_last_q) begin
        layer_done_q <= 1'b1;
        busy_q       <= 1'b0;
      end
    end
  end

  // Even-row line buffer; contents need no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept && (state_q == S_FILL)) begin
      line_buf[col_q[AW-1:0]] <= pd_if.in_pd;
    end
  end

  // Output pair register; reloads on the same cycle it drains.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load_out) begin
      out_a_q     <= (state_q == S_PAIR) ? line_buf[col_q[AW-1:0]] : pd_if.in_pd;
      out_b_q     <= pd_if.in_pd;
      out_valid_q <= 1'b1;
      out_last_q  <= col_end && row_last;
    end else if (pd_if.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign pd_if.in_ready  = in_ready_c;
  assign pd_if.out_a_pd  = out_a_q;
  assign pd_if.out_b_pd  = out_b_q;
  assign pd_if.out_valid = out_valid_q;
  assign pd_if.out_last  = out_last_q;
  assign busy            = busy_q;
  assign layer_done      = layer_done_q;

endmodule
